// File: rtl/cpu_muldiv_seq_if.sv
// Execute-stage multiply request/response bundle between EX and the
// iterative multiply sequencer.
interface cpu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             cpu_stall;
  logic             req;
  logic             req_hi;
  logic [WIDTH-1:0] req_x;
  logic [WIDTH-1:0] req_y;
  logic             flush;
  logic             ex_stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;

  modport master (
    output cpu_stall, req, req_hi, req_x, req_y, flush,
    input  ex_stall, result, result_valid, busy
  );

  modport slave (
    input  cpu_stall, req, req_hi, req_x, req_y, flush,
    output ex_stall, result, result_valid, busy
  );
endinterface

// File: rtl/cpu_muldiv_seq.sv
// Iterative signed multiply sequencer for the execute stage. Multiplies
// operand magnitudes STEPS bits per cycle, applies the sign at the end and
// keeps the last full product so a lo/hi pair costs a single multiply.
//
// state | meaning
// IDLE  | no multiply in flight; cache hits answered combinationally
// RUN   | shift-add iterations, counter counts down from N
// DONE  | sign applied, product cached, selected word returned
module cpu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input logic             clk,
  input logic             rst,
  cpu_muldiv_seq_if.slave bus
);
  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] cache_q;
  logic [WIDTH-1:0]   cx_q, cy_q;
  logic               cache_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               ex_stall_q;

  logic               hit;
  logic [WIDTH-1:0]   mag_x, mag_y;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] product;
  logic               load, step, wr_cache, rv;
  logic               ex_stall_c;
  logic [WIDTH-1:0]   res_word;

  // Operand magnitudes, cache compare, signed product and this cycle's partial sum.
  always_comb begin
    hit     = cache_valid_q && (bus.req_x == cx_q) && (bus.req_y == cy_q);
    // Negating 0x80000000 leaves 0x80000000, which read unsigned is 2^31.
    mag_x   = bus.req_x[WIDTH-1] ? -bus.req_x : bus.req_x;
    mag_y   = bus.req_y[WIDTH-1] ? -bus.req_y : bus.req_y;
    product = neg_q ? -acc_q : acc_q;
    partial = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  // Next-state and handshake outputs; cpu_stall freezes everything.
  always_comb begin
    state_d    = state_q;
    ex_stall_c = 1'b0;
    rv         = 1'b0;
    res_word   = result_q;
    load       = 1'b0;
    step       = 1'b0;
    wr_cache   = 1'b0;
    if (bus.cpu_stall) begin
      ex_stall_c = ex_stall_q;
    end else if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            if (hit) begin
              rv       = 1'b1;
              res_word = bus.req_hi ? cache_q[2*WIDTH-1:WIDTH] : cache_q[WIDTH-1:0];
            end else begin
              load       = 1'b1;
              ex_stall_c = 1'b1;
              state_d    = RUN;
            end
          end
        end
        RUN: begin
          if (!bus.req) begin
            state_d = IDLE;
          end else begin
            step       = 1'b1;
            ex_stall_c = 1'b1;
            if (cnt_q == CW'(1)) state_d = DONE;
          end
        end
        DONE: begin
          rv       = 1'b1;
          wr_cache = 1'b1;
          res_word = bus.req_hi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register and last-driven ex_stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ex_stall_q <= 1'b0;
    end else if (!bus.cpu_stall) begin
      state_q    <= state_d;
      ex_stall_q <= ex_stall_c;
    end
  end

  // Datapath: operand latch, shift-add iteration, product cache and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      neg_q         <= 1'b0;
      cache_q       <= '0;
      cx_q          <= '0;
      cy_q          <= '0;
      cache_valid_q <= 1'b0;
      result_q      <= '0;
    end else if (!bus.cpu_stall) begin
      if (rv) result_q <= res_word;
      if (load) begin
        cnt_q    <= CW'(N);
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, mag_x};
        mplier_q <= mag_y;
        neg_q    <= bus.req_x[WIDTH-1] ^ bus.req_y[WIDTH-1];
      end
      if (step) begin
        acc_q    <= acc_q + partial;
        mcand_q  <= mcand_q << STEPS;
        mplier_q <= mplier_q >> STEPS;
        cnt_q    <= cnt_q - 1'b1;
      end
      if (wr_cache) begin
        cache_q       <= product;
        cx_q          <= bus.req_x;
        cy_q          <= bus.req_y;
        cache_valid_q <= 1'b1;
      end
    end
  end

  assign bus.ex_stall     = ex_stall_c;
  assign bus.result       = res_word;
  assign bus.result_valid = rv;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_muldiv_seq.sv
// Scoreboard bench for cpu_muldiv_seq: directed multiplies push expected
// results; a negedge monitor pops and compares on every result_valid and
// also evaluates the stall-count and reset checks posted by the driver.
module tb_cpu_muldiv_seq;
  logic clk, rst;
  logic cpu_stall, flush, req_hi;
  logic [31:0] req_x, req_y;
  logic req_v[2];

  int n_vec, n_err;
  logic [31:0] q0[$], q1[$];
  string       pn_q[$];
  logic [31:0] pa_q[$], pe_q[$];
  logic [31:0] mon_e, mon_a;
  string       mon_n;

  cpu_muldiv_seq_if #(.WIDTH(32)) f0 ();
  cpu_muldiv_seq_if #(.WIDTH(32)) f1 ();

  assign f0.cpu_stall = cpu_stall;
  assign f0.flush     = flush;
  assign f0.req_hi    = req_hi;
  assign f0.req_x     = req_x;
  assign f0.req_y     = req_y;
  assign f0.req       = req_v[0];
  assign f1.cpu_stall = cpu_stall;
  assign f1.flush     = flush;
  assign f1.req_hi    = req_hi;
  assign f1.req_x     = req_x;
  assign f1.req_y     = req_y;
  assign f1.req       = req_v[1];

  cpu_muldiv_seq #(.WIDTH(32), .STEPS(1)) u0 (.clk(clk), .rst(rst), .bus(f0));
  cpu_muldiv_seq #(.WIDTH(32), .STEPS(4)) u1 (.clk(clk), .rst(rst), .bus(f1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sole owner of the comparison counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (f0.result_valid) begin
        n_vec++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result0: got %08h with nothing expected", f0.result);
        end else begin
          mon_e = q0.pop_front();
          if (f0.result !== mon_e) begin
            n_err++;
            $display("FAIL result0: got %08h expected %08h", f0.result, mon_e);
          end
        end
      end
      if (f1.result_valid) begin
        n_vec++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result1: got %08h with nothing expected", f1.result);
        end else begin
          mon_e = q1.pop_front();
          if (f1.result !== mon_e) begin
            n_err++;
            $display("FAIL result1: got %08h expected %08h", f1.result, mon_e);
          end
        end
      end
    end
    while (pn_q.size() > 0) begin
      mon_n = pn_q.pop_front();
      mon_a = pa_q.pop_front();
      mon_e = pe_q.pop_front();
      n_vec++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL %s: got %0h expected %0h", mon_n, mon_a, mon_e);
      end
    end
  end

  task automatic post(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pn_q.push_back(nm);
    pa_q.push_back(act);
    pe_q.push_back(exp);
  endtask

  // Issue one multiply on instance inst; count ex_stall cycles until release.
  task automatic mul(input int inst, input logic [31:0] x, input logic [31:0] y,
                     input logic h, input logic [31:0] er, input int es,
                     input int cs_at = -1, input int fl_at = -1);
    int  stalls;
    bit  done;
    logic st;
    if (fl_at < 0) begin
      if (inst == 0) q0.push_back(er);
      else           q1.push_back(er);
    end
    req_x = x; req_y = y; req_hi = h;
    req_v[inst] = 1'b1;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      st = (inst == 0) ? f0.ex_stall : f1.ex_stall;
      if (!st) begin
        done = 1'b1;
      end else begin
        stalls++;
        @(posedge clk); #1;
        if (stalls == cs_at) cpu_stall = 1'b1;
        if (cs_at >= 0 && stalls == cs_at + 5) cpu_stall = 1'b0;
        if (stalls == fl_at) flush = 1'b1;
      end
    end
    @(posedge clk); #1;
    req_v[inst] = 1'b0;
    flush = 1'b0;
    cpu_stall = 1'b0;
    post("stall_cycles", 32'(stalls), 32'(es));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; cpu_stall = 1'b0; flush = 1'b0; req_hi = 1'b0;
    req_x = '0; req_y = '0; req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    post("rst_result", f0.result, 32'h0);
    post("rst_result_valid", 32'(f0.result_valid), 32'h0);
    post("rst_busy", 32'(f0.busy), 32'h0);
    post("rst_ex_stall", 32'(f0.ex_stall), 32'h0);
    @(posedge clk); #1;

    mul(0, 32'd3, 32'd5, 1'b0, 32'h0000000F, 33);
    mul(0, 32'hFFFFFFF9, 32'd6, 1'b0, 32'hFFFFFFD6, 33);
    mul(0, 32'hFFFFFFF9, 32'd6, 1'b1, 32'hFFFFFFFF, 0);
    mul(0, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 33);
    mul(0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 0);
    mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 33);

    mul(0, 32'd2, 32'd3, 1'b0, 32'd6, 33);
    mul(0, 32'd10, 32'd20, 1'b0, 32'd0, 10, -1, 10);
    @(negedge clk);
    post("flush_busy", 32'(f0.busy), 32'h0);
    @(posedge clk); #1;
    mul(0, 32'd2, 32'd3, 1'b0, 32'd6, 0);
    mul(0, 32'd10, 32'd20, 1'b0, 32'd200, 33);

    mul(0, 32'd1234, 32'd5678, 1'b0, 32'd7006652, 38, 10);

    // Reset in the middle of a run, with 1234x5678 cached.
    req_x = 32'd10; req_y = 32'd7; req_hi = 1'b0; req_v[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; req_v[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    post("midrun_rst_result", f0.result, 32'h0);
    post("midrun_rst_result_valid", 32'(f0.result_valid), 32'h0);
    post("midrun_rst_busy", 32'(f0.busy), 32'h0);
    post("midrun_rst_ex_stall", 32'(f0.ex_stall), 32'h0);
    @(posedge clk); #1;
    mul(0, 32'd1234, 32'd5678, 1'b0, 32'd7006652, 33);

    mul(1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h242D2080, 9);
    mul(1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hF8CC93D6, 0);

    repeat (3) @(posedge clk);
    #1;
    post("q0_drained", 32'(q0.size()), 32'h0);
    post("q1_drained", 32'(q1.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
